// File: rtl/branch_pkg.sv
// Shared branch-unit definitions: branch type encodings and 2-bit history counter constants.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLEZ = 3'b011,
    BR_BGTZ = 3'b100,
    BR_BLTZ = 3'b101,
    BR_BGEZ = 3'b110,
    BR_RSVD = 3'b111
  } br_type_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;
  localparam logic [1:0] CTR_RST = CTR_WNT;

endpackage

// File: rtl/sat_ctr2.sv
// Saturating 2-bit up/down counter step used at the history table write port.
module sat_ctr2
  import branch_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] next
);

  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != CTR_ST) next = cur + 2'd1;
    end else begin
      if (cur != CTR_SNT) next = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolve unit with a 2-bit bimodal history table and optional statistics.
// Optional counters enabled by defining BRANCH_STATS_EN; otherwise stat ports read 0.
module branch_unit
  import branch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PC_W-1:0]   id_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [2:0]        ex_br_type,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [DATA_W-1:0] ex_rs,
  input  logic [DATA_W-1:0] ex_rt,
  input  logic              ex_pred,
  output logic              res_valid,
  output logic              res_taken,
  output logic              res_mispredict,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] look_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       ctr_next;
  logic             is_br;
  logic             cond;
  logic             mispred;
  logic             rs_neg;
  logic             rs_zero;
  logic             res_valid_q, res_taken_q, res_mp_q;
  logic             unused_pc_bits;

  assign look_idx = id_pc[IDX_W+1:2];
  assign upd_idx  = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{id_pc[1:0], ex_pc[1:0]};

  // Read-before-write: lookup sees the registered entry, the update lands on the edge.
  assign pred_taken = bht_q[look_idx][1];

  assign rs_neg  = ex_rs[DATA_W-1];
  assign rs_zero = (ex_rs == '0);

  always_comb begin
    cond  = 1'b0;
    is_br = ex_valid;
    case (br_type_e'(ex_br_type))
      BR_BEQ:  cond = (ex_rs == ex_rt);
      BR_BNE:  cond = (ex_rs != ex_rt);
      BR_BLEZ: cond = rs_neg | rs_zero;
      BR_BGTZ: cond = ~rs_neg & ~rs_zero;
      BR_BLTZ: cond = rs_neg;
      BR_BGEZ: cond = ~rs_neg;
      default: is_br = 1'b0;
    endcase
  end

  assign mispred = is_br & (cond != ex_pred);

  sat_ctr2 u_sat_ctr2 (
    .cur   (bht_q[upd_idx]),
    .taken (cond),
    .next  (ctr_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_RST;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      res_mp_q    <= 1'b0;
    end else begin
      res_valid_q <= is_br;
      res_taken_q <= is_br & cond;
      res_mp_q    <= mispred;
      if (is_br) bht_q[upd_idx] <= ctr_next;
    end
  end

  assign res_valid      = res_valid_q;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mp_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (is_br) begin
      if (stat_br_q != '1) stat_br_q <= stat_br_q + 32'd1;
      if (mispred && stat_mp_q != '1) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed sequences, a vector table and randomized resolves vs a model.
module tb_branch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] id_pc = '0;
  logic        pred_taken;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_br_type = '0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_rs = '0;
  logic [31:0] ex_rt = '0;
  logic        ex_pred = 1'b0;
  logic        res_valid, res_taken, res_mispredict;
  logic [31:0] stat_branches, stat_mispredicts;

  branch_unit #(.DATA_W(32), .PC_W(32), .BHT_DEPTH(16)) dut (
    .clock(clock), .reset(reset), .id_pc(id_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_br_type(ex_br_type), .ex_pc(ex_pc),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_pred(ex_pred),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  int vecs = 0;
  int errs = 0;

  // Reference model: plain integer counters per table slot and running statistics.
  int          m_bht [16];
  longint      m_nbr;
  longint      m_nmp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_cond(input int t, input logic [31:0] rs, input logic [31:0] rt);
    int s;
    s = int'(rs);
    case (t)
      1: return rs == rt;
      2: return rs != rt;
      3: return s <= 0;
      4: return s > 0;
      5: return s < 0;
      6: return s >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sat32(input longint n);
    return (n > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : n[31:0];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_nbr = 0;
    m_nmp = 0;
  endtask

  task automatic chk_stats();
`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_branches, sat32(m_nbr));
    chk("stat_mispredicts", stat_mispredicts, sat32(m_nmp));
`else
    chk("stat_branches_off", stat_branches, 32'd0);
    chk("stat_mispredicts_off", stat_mispredicts, 32'd0);
`endif
  endtask

  // Called #1 after a rising edge: drive, check the lookup, cross the edge, check the result.
  task automatic resolve(input bit v, input int t, input logic [31:0] pc, input logic [31:0] rs,
                         input logic [31:0] rt, input bit pred, input logic [31:0] lookpc);
    bit c, br;
    ex_valid = v; ex_br_type = 3'(t); ex_pc = pc; ex_rs = rs; ex_rt = rt; ex_pred = pred;
    id_pc = lookpc;
    #1;
    chk("pred_pre", {31'd0, pred_taken}, {31'd0, m_bht[m_idx(lookpc)] >= 2});
    br = v && (t >= 1) && (t <= 6);
    c  = m_cond(t, rs, rt);
    if (br) begin
      m_bht[m_idx(pc)] = c ? ((m_bht[m_idx(pc)] < 3) ? m_bht[m_idx(pc)] + 1 : 3)
                           : ((m_bht[m_idx(pc)] > 0) ? m_bht[m_idx(pc)] - 1 : 0);
      m_nbr++;
      if (c != pred) m_nmp++;
    end
    @(posedge clock); #1;
    chk("res_valid", {31'd0, res_valid}, {31'd0, br});
    chk("res_taken", {31'd0, res_taken}, {31'd0, br && c});
    chk("res_mispredict", {31'd0, res_mispredict}, {31'd0, br && (c != pred)});
    chk_stats();
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_br_type = '0;
    @(posedge clock); #1;
  endtask

  // Reset with a live resolve on the inputs: the resolve must not land.
  task automatic do_reset();
    ex_valid = 1'b1; ex_br_type = 3'd1; ex_pc = 32'h40; ex_rs = 32'd3; ex_rt = 32'd3; ex_pred = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    ex_valid = 1'b0;
    m_reset();
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_taken", {31'd0, res_taken}, 32'd0);
    chk("rst_res_mp", {31'd0, res_mispredict}, 32'd0);
    chk_stats();
    for (int i = 0; i < 16; i++) begin
      id_pc = 32'(i * 4);
      #1;
      chk("rst_pred", {31'd0, pred_taken}, 32'd0);
    end
  endtask

  typedef struct {
    bit          v;
    logic [2:0]  t;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    bit          pred;
    bit          exp_valid;
    bit          exp_taken;
    bit          exp_mp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1, 3'b101, 32'h100, 32'h8000_0000, 32'h0, 0, 1, 1, 1};
    tbl[1] = '{1, 3'b110, 32'h104, 32'h0,         32'h9, 1, 1, 1, 0};
    tbl[2] = '{1, 3'b100, 32'h108, 32'h0,         32'h5, 1, 1, 0, 1};
    tbl[3] = '{1, 3'b111, 32'h10C, 32'h7,         32'h7, 1, 0, 0, 0};
    tbl[4] = '{1, 3'b011, 32'h110, 32'hFFFF_FFFF, 32'h0, 1, 1, 1, 0};
    tbl[5] = '{1, 3'b011, 32'h114, 32'h1,         32'h0, 0, 1, 0, 0};
    tbl[6] = '{1, 3'b100, 32'h118, 32'h7FFF_FFFF, 32'h0, 0, 1, 1, 1};
    tbl[7] = '{1, 3'b000, 32'h11C, 32'h3,         32'h3, 1, 0, 0, 0};
    tbl[8] = '{0, 3'b001, 32'h120, 32'h3,         32'h3, 0, 0, 0, 0};
    tbl[9] = '{1, 3'b010, 32'h124, 32'h4,         32'h4, 0, 1, 0, 0};

    m_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state and first lookup
    id_pc = 32'h40;
    #1;
    chk("init_pred_0x40", {31'd0, pred_taken}, 32'd0);
    chk("init_res_valid", {31'd0, res_valid}, 32'd0);
    chk("init_res_taken", {31'd0, res_taken}, 32'd0);
    chk("init_res_mp", {31'd0, res_mispredict}, 32'd0);
    chk_stats();

    // BEQ taken at 0x40, predicted not-taken
    resolve(1, 1, 32'h40, 32'd5, 32'd5, 0, 32'h40);
    chk("beq_res_valid", {31'd0, res_valid}, 32'd1);
    chk("beq_res_mp", {31'd0, res_mispredict}, 32'd1);
    id_pc = 32'h40; #1;
    chk("beq_pred_after", {31'd0, pred_taken}, 32'd1);
    idle();

    // Back-to-back BNE at 0x44: three taken then one not-taken, each one step
    for (int i = 0; i < 4; i++) begin
      resolve(1, 2, 32'h44, 32'd1, (i < 3) ? 32'd2 : 32'd1, 1, 32'h44);
      id_pc = 32'h44; #1;
      chk("bne_pred_after", {31'd0, pred_taken}, 32'd1);
    end
    chk("bne_final_model", 32'(m_bht[1]), 32'd2);
    idle();

    // Same-cycle lookup and update at 0x48: read-before-write
    resolve(1, 1, 32'h48, 32'd9, 32'd9, 0, 32'h48);
    chk("rbw_pred_next", {31'd0, pred_taken}, 32'd1);
    idle();

    // Vector table
    for (int i = 0; i < 10; i++) begin
      resolve(tbl[i].v, int'(tbl[i].t), tbl[i].pc, tbl[i].rs, tbl[i].rt, tbl[i].pred, tbl[i].pc);
      chk("tbl_valid", {31'd0, res_valid}, {31'd0, tbl[i].exp_valid});
      chk("tbl_taken", {31'd0, res_taken}, {31'd0, tbl[i].exp_taken});
      chk("tbl_mp", {31'd0, res_mispredict}, {31'd0, tbl[i].exp_mp});
    end
    // Reserved type must not have moved its entry (0x10C -> index 3, still weakly not-taken)
    id_pc = 32'h10C; #1;
    chk("rsvd_no_update", {31'd0, pred_taken}, 32'd0);
    idle();

    // Statistics: 10 resolves with 3 mispredicts after a reset
    do_reset();
    for (int i = 0; i < 10; i++)
      resolve(1, 1, 32'(i * 4), 32'd8, 32'd8, (i >= 3), 32'h0);
`ifdef BRANCH_STATS_EN
    chk("stats10_br", stat_branches, 32'd10);
    chk("stats10_mp", stat_mispredicts, 32'd3);
`else
    chk("stats10_br_off", stat_branches, 32'd0);
    chk("stats10_mp_off", stat_mispredicts, 32'd0);
`endif
    idle();

    // Randomized resolves against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rs, rt, pc, lk;
      int sel, t;
      t  = int'($urandom_range(0, 7));
      pc = $urandom;
      lk = ($urandom_range(0, 3) == 0) ? pc : $urandom;
      rt = $urandom;
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: rs = 32'h0;
        1: rs = rt;
        2: rs = 32'h8000_0000;
        3: rs = 32'hFFFF_FFFF;
        default: rs = $urandom;
      endcase
      resolve($urandom_range(0, 7) != 0, t, pc, rs, rt, 1'($urandom), lk);
    end

    // Mid-stream reset restores every entry and the counters
    do_reset();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
